// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and forward round-function helpers.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // GF(2^8) multiply-by-2 with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Byte i lives at bits [127-8i -: 8]; row = i%4, col = i/4.
  function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[BLOCK_W-1-BYTE_W*i -: 8] = SBOX[x[BLOCK_W-1-BYTE_W*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[BLOCK_W-1-BYTE_W*(4*c+r) -: 8] = x[BLOCK_W-1-BYTE_W*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[BLOCK_W-1-WORD_W*c      -: 8];
      a1 = x[BLOCK_W-1-WORD_W*c - 8  -: 8];
      a2 = x[BLOCK_W-1-WORD_W*c - 16 -: 8];
      a3 = x[BLOCK_W-1-WORD_W*c - 24 -: 8];
      o[BLOCK_W-1-WORD_W*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[BLOCK_W-1-WORD_W*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[BLOCK_W-1-WORD_W*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[BLOCK_W-1-WORD_W*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-expansion step: current round key and rcon -> next round key.
module aes128_key_step
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] rk,
  input  logic [7:0]         rcon,
  output logic [BLOCK_W-1:0] next_key_c
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] temp;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign w0 = rk[127:96];
  assign w1 = rk[95:64];
  assign w2 = rk[63:32];
  assign w3 = rk[31:0];

  // SubWord(RotWord(w3)) with the round constant folded into the top byte.
  assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_c = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock, on-the-fly key expansion.
// Optional: define AES_CLEAR_ON_DONE_EN to wipe st/rk/rcon on the output handshake.
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int unsigned RND_W = $clog2(NUM_ROUNDS + 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

  aes_fsm_e           fsm, fsm_nx;
  logic [BLOCK_W-1:0] st, st_nx;
  logic [BLOCK_W-1:0] rk, rk_nx;
  logic [7:0]         rcon, rcon_nx;
  logic [RND_W-1:0]   rnd, rnd_nx;

  logic [BLOCK_W-1:0] nk_c;
  logic [BLOCK_W-1:0] sr_c;
  logic [BLOCK_W-1:0] mc_c;
  logic               last_c;

  aes128_key_step u_key_step (
    .rk         (rk),
    .rcon       (rcon),
    .next_key_c (nk_c)
  );

  assign sr_c   = shift_rows(sub_bytes(st));
  assign mc_c   = mix_columns(sr_c);
  assign last_c = (rnd == LAST_RND);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm  <= IDLE;
      st   <= '0;
      rk   <= '0;
      rcon <= 8'h01;
      rnd  <= '0;
    end else begin
      fsm  <= fsm_nx;
      st   <= st_nx;
      rk   <= rk_nx;
      rcon <= rcon_nx;
      rnd  <= rnd_nx;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    fsm_nx  = fsm;
    st_nx   = st;
    rk_nx   = rk;
    rcon_nx = rcon;
    rnd_nx  = rnd;
    case (fsm)
      IDLE: begin
        if (in_valid && in_ready) begin
          st_nx   = in_data ^ in_key;
          rk_nx   = in_key;
          rcon_nx = 8'h01;
          rnd_nx  = RND_W'(1);
          fsm_nx  = ROUND;
        end
      end
      ROUND: begin
        st_nx   = (last_c ? sr_c : mc_c) ^ nk_c;
        rk_nx   = nk_c;
        rcon_nx = xtime(rcon);
        if (last_c) begin
          fsm_nx = DONE;
        end else begin
          rnd_nx = rnd + RND_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_nx = IDLE;
`ifdef AES_CLEAR_ON_DONE_EN
          st_nx   = '0;
          rk_nx   = '0;
          rcon_nx = 8'h01;
`endif
        end
      end
      default: fsm_nx = IDLE;
    endcase
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (fsm == IDLE) && !rst;
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign out_data  = st;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter against an arithmetic AES reference model.
module tb_aes128_encrypt_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int errors;
  int checks;

  logic [7:0] sbox_tbl [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_encrypt_iter #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (field arithmetic, byte arrays) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  // S-box = affine map of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] xb;
    logic [7:0] yb;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      xb = 8'(x);
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (x != 0 && gmul(xb, yb) == 8'h01) inv = yb;
      end
      sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt,
                                               input int nr);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] w [4];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8];
      k[i] = key[127-8*i -: 8];
      s[i] = s[i] ^ k[i];
    end
    rc = 8'h01;
    for (int rd = 1; rd <= nr; rd++) begin
      w[0] = sbox_tbl[k[13]] ^ rc;
      w[1] = sbox_tbl[k[14]];
      w[2] = sbox_tbl[k[15]];
      w[3] = sbox_tbl[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ w[j];
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      rc = gmul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sbox_tbl[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rd != nr)
            s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4]) ^
                       t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic run_block(input string name, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp, input int stall);
    int lat;
    logic [127:0] after_exp;
    @(negedge clk);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_data   = pt;
    in_key    = key;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept in_ready=%b want 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL %s latency got=%0d want 11", name, lat);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL %s data got=%h want %h", name, out_data, exp);
    end
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
`ifdef AES_CLEAR_ON_DONE_EN
    after_exp = '0;
`else
    after_exp = exp;
`endif
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s post_handshake in_ready=%b out_valid=%b busy=%b want 1 0 0",
               name, in_ready, out_valid, busy);
    end
    checks++;
    if (out_data !== after_exp) begin
      errors++;
      $display("FAIL %s idle_data got=%h want %h", name, out_data, after_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b busy=%b data=%h want 0 0 0 0",
               in_ready, out_valid, busy, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_fips();
    run_block("fips_b", KEY_B, PT_B, CT_B, 0);
    run_block("fips_c1", KEY_C, PT_C, CT_C, 0);
  endtask

  task automatic test_random();
    logic [127:0] k;
    logic [127:0] p;
    for (int n = 0; n < 6; n++) begin
      k = rand128();
      p = (n == 0) ? 128'h0 : rand128();
      if (n == 1) k = '1;
      run_block($sformatf("random%0d", n), k, p, ref_encrypt(k, p, 10), $urandom_range(0, 3));
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = PT_B;
    in_key    = KEY_B;
    @(negedge clk);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      in_data = rand128();
      in_key  = rand128();
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL backpressure latency got=%0d want 11", lat);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_data = rand128();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== CT_B) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL backpressure_hold cyc=%0d valid=%b ready=%b busy=%b data=%h want 1 0 1 %h",
                   i, out_valid, in_ready, busy, out_data, CT_B);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int acc_cnt;
    int out_cnt;
    int acc_t [2];
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    acc_cnt = 0; out_cnt = 0; cyc = 0;
    acc_t[0] = 0; acc_t[1] = 0;
    while (out_cnt < 2 && cyc < 80) begin
      if (acc_cnt == 2 && in_ready !== 1'b1) in_valid = 1'b0;
      if (in_ready === 1'b1) begin
        in_data = PT_C;
        in_key  = KEY_C;
      end else begin
        in_data = rand128();
        in_key  = rand128();
      end
      if (in_valid && in_ready === 1'b1) begin
        if (acc_cnt < 2) acc_t[acc_cnt] = cyc;
        acc_cnt++;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== CT_C) begin
          errors++;
          $display("FAIL b2b_data%0d got=%h want %h", out_cnt, out_data, CT_C);
        end
        out_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (out_cnt !== 2 || acc_cnt !== 2) begin
      errors++;
      $display("FAIL b2b_count outputs=%0d accepts=%0d want 2 2", out_cnt, acc_cnt);
    end
    checks++;
    if (acc_t[1] - acc_t[0] !== 12) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d want 12", acc_t[1] - acc_t[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = PT_C;
    in_key    = KEY_C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy_before got=%b want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid valid=%b busy=%b ready=%b data=%h want 0 0 0 0",
               out_valid, busy, in_ready, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    run_block("reset_mid_fips_b", KEY_B, PT_B, CT_B, 1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
